// File: rtl/retire_trace_buffer_if.sv
// Retire-side and drain-side buses of the commit-trace buffer.
// The master side is the core plus the trace consumer; the slave side is the buffer.
interface retire_trace_buffer_if #(
    parameter int LANES = 2,
    parameter int XLEN  = 32
);
    localparam int LW = $clog2(LANES) | 1;

    logic [LANES-1:0]      ret_valid;
    logic [LANES*XLEN-1:0] ret_pc;
    logic [LANES*5-1:0]    ret_rd;
    logic [LANES-1:0]      ret_we;
    logic [LANES*XLEN-1:0] ret_wdata;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [XLEN-1:0]       rd_pc;
    logic [4:0]            rd_rd;
    logic                  rd_we;
    logic [XLEN-1:0]       rd_wdata;
    logic [LW-1:0]         rd_lane;

    modport master (
        output ret_valid, ret_pc, ret_rd, ret_we, ret_wdata, rd_ready,
        input  rd_valid, rd_pc, rd_rd, rd_we, rd_wdata, rd_lane
    );

    modport slave (
        input  ret_valid, ret_pc, ret_rd, ret_we, ret_wdata, rd_ready,
        output rd_valid, rd_pc, rd_rd, rd_we, rd_wdata, rd_lane
    );
endinterface

// File: rtl/retire_trace_buffer.sv
// N-lane commit-trace capture buffer. Retiring instructions are written into a
// circular buffer while armed; a trigger starts a post-trigger window, after which
// the buffer freezes and drains oldest-first over the rd_* valid/ready port.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE   (0) | no capture; waiting for arm
// ARMED  (1) | capturing every valid lane, overwriting the oldest when full
// TRIG   (2) | trigger seen; capturing until the post-trigger count runs out
// FROZEN (3) | no capture; draining entries oldest-first, IDLE when empty
module retire_trace_buffer #(
    parameter  int LANES     = 2,
    parameter  int DEPTH     = 64,
    parameter  int XLEN      = 32,
    parameter  int POST_TRIG = 16,
    localparam int CW        = $clog2(DEPTH + 1),
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW        = $clog2(LANES) | 1
) (
    input  logic                 clock,
    input  logic                 reset,
    retire_trace_buffer_if.slave bus,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 trig_en,
    input  logic [XLEN-1:0]      trig_pc,
    input  logic                 force_trig,
    output logic [1:0]           state,
    output logic [CW-1:0]        count,
    output logic                 wrapped
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_TRIG   = 2'd2;
    localparam logic [1:0] ST_FROZEN = 2'd3;

    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [4:0]      mem_rd    [DEPTH];
    logic            mem_we    [DEPTH];
    logic [XLEN-1:0] mem_wdata [DEPTH];
    logic [LW-1:0]   mem_lane  [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    post_cnt;

    logic             capture;
    logic [CW-1:0]    allowed;
    logic [CW-1:0]    acc;
    logic [CW-1:0]    n_wr;
    logic [LANES-1:0] lane_wr;
    logic [AW-1:0]    slot [LANES];
    logic             pc_hit;
    logic             trig_hit;
    logic [CW:0]      count_sum;
    logic             overflow;
    logic [CW-1:0]    count_next;
    logic [AW-1:0]    rd_idx;
    logic             rd_valid_i;
    logic             pop;

    // Compact valid lanes into consecutive slots, limited to what the current state may write.
    always_comb begin
        capture = !abort && ((state == ST_ARMED) || (state == ST_TRIG));
        allowed = (state == ST_TRIG) ? post_cnt : CW'(LANES);
        acc     = '0;
        n_wr    = '0;
        lane_wr = '0;
        for (int i = 0; i < LANES; i++) begin
            slot[i]    = wr_ptr + acc[AW-1:0];
            lane_wr[i] = capture && bus.ret_valid[i] && (acc < allowed);
            if (bus.ret_valid[i]) begin
                acc = acc + CW'(1);
            end
            if (lane_wr[i]) begin
                n_wr = n_wr + CW'(1);
            end
        end
    end

    // PC-match trigger: any valid lane retiring at trig_pc.
    always_comb begin
        pc_hit = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (bus.ret_valid[i] && (bus.ret_pc[i*XLEN +: XLEN] == trig_pc)) begin
                pc_hit = 1'b1;
            end
        end
    end

    assign trig_hit   = force_trig | (trig_en & pc_hit);

    // Fullness: count saturates at DEPTH, and anything beyond that overwrote the oldest entry.
    assign count_sum  = {1'b0, count} + {1'b0, n_wr};
    assign overflow   = count_sum > (CW + 1)'(DEPTH);
    assign count_next = overflow ? CW'(DEPTH) : count_sum[CW-1:0];

    // Oldest entry sits count slots behind the write pointer (count==DEPTH wraps to wr_ptr).
    assign rd_idx     = wr_ptr - count[AW-1:0];
    assign rd_valid_i = (state == ST_FROZEN) && (count != '0);
    assign pop        = rd_valid_i && bus.rd_ready;

    // Trace storage; contents are only observable through rd_*, which is gated by rd_valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (lane_wr[i]) begin
                mem_pc[slot[i]]    <= bus.ret_pc[i*XLEN +: XLEN];
                mem_rd[slot[i]]    <= bus.ret_rd[i*5 +: 5];
                mem_we[slot[i]]    <= bus.ret_we[i];
                mem_wdata[slot[i]] <= bus.ret_wdata[i*XLEN +: XLEN];
                mem_lane[slot[i]]  <= LW'(i);
            end
        end
    end

    // Capture/trigger/drain sequencing; abort beats every other input.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            wr_ptr   <= '0;
            wrapped  <= 1'b0;
            post_cnt <= '0;
        end else if (abort) begin
            state    <= ST_IDLE;
            count    <= '0;
            wr_ptr   <= '0;
            wrapped  <= 1'b0;
            post_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state   <= ST_ARMED;
                        count   <= '0;
                        wr_ptr  <= '0;
                        wrapped <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    wr_ptr <= wr_ptr + n_wr[AW-1:0];
                    count  <= count_next;
                    if (overflow) begin
                        wrapped <= 1'b1;
                    end
                    if (trig_hit) begin
                        post_cnt <= CW'(POST_TRIG);
                        state    <= (POST_TRIG == 0) ? ST_FROZEN : ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    wr_ptr   <= wr_ptr + n_wr[AW-1:0];
                    count    <= count_next;
                    post_cnt <= post_cnt - n_wr;
                    if (overflow) begin
                        wrapped <= 1'b1;
                    end
                    if (post_cnt == n_wr) begin
                        state <= ST_FROZEN;
                    end
                end
                default: begin
                    // A trigger with nothing captured leaves FROZEN empty; fall straight back.
                    if (count == '0) begin
                        state <= ST_IDLE;
                    end else if (pop) begin
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.rd_valid = rd_valid_i;
    assign bus.rd_pc    = rd_valid_i ? mem_pc[rd_idx]    : '0;
    assign bus.rd_rd    = rd_valid_i ? mem_rd[rd_idx]    : '0;
    assign bus.rd_we    = rd_valid_i ? mem_we[rd_idx]    : 1'b0;
    assign bus.rd_wdata = rd_valid_i ? mem_wdata[rd_idx] : '0;
    assign bus.rd_lane  = rd_valid_i ? mem_lane[rd_idx]  : '0;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: two instances (POST_TRIG=2 and POST_TRIG=0) share
// one stimulus stream and are compared every cycle against a queue-based model.
module tb_retire_trace_buffer;

    localparam int DEPTH = 8;
    localparam int POST0 = 2;
    localparam int POST1 = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wdata;
        logic        lane;
    } ent_t;

    logic        clock;
    logic        reset;
    logic        arm, abort, trig_en, force_trig, rd_ready;
    logic [31:0] trig_pc;
    logic [1:0]  ret_valid;
    logic [63:0] ret_pc, ret_wdata;
    logic [9:0]  ret_rd;
    logic [1:0]  ret_we;

    logic [1:0]  st  [2];
    logic [3:0]  cnt [2];
    logic        wrp [2];
    logic        rv  [2];
    logic [31:0] rpc [2];
    logic [4:0]  rrd [2];
    logic        rwe [2];
    logic [31:0] rwd [2];
    logic [0:0]  rln [2];

    int n_vec = 0;
    int n_err = 0;

    int   ms [2];
    int   mp [2];
    bit   mw [2];
    ent_t mq [2][$];

    retire_trace_buffer_if #(.LANES(2), .XLEN(32)) bus0 ();
    retire_trace_buffer_if #(.LANES(2), .XLEN(32)) bus1 ();

    assign bus0.ret_valid = ret_valid;
    assign bus0.ret_pc    = ret_pc;
    assign bus0.ret_rd    = ret_rd;
    assign bus0.ret_we    = ret_we;
    assign bus0.ret_wdata = ret_wdata;
    assign bus0.rd_ready  = rd_ready;
    assign bus1.ret_valid = ret_valid;
    assign bus1.ret_pc    = ret_pc;
    assign bus1.ret_rd    = ret_rd;
    assign bus1.ret_we    = ret_we;
    assign bus1.ret_wdata = ret_wdata;
    assign bus1.rd_ready  = rd_ready;

    assign rv[0]  = bus0.rd_valid;
    assign rpc[0] = bus0.rd_pc;
    assign rrd[0] = bus0.rd_rd;
    assign rwe[0] = bus0.rd_we;
    assign rwd[0] = bus0.rd_wdata;
    assign rln[0] = bus0.rd_lane;
    assign rv[1]  = bus1.rd_valid;
    assign rpc[1] = bus1.rd_pc;
    assign rrd[1] = bus1.rd_rd;
    assign rwe[1] = bus1.rd_we;
    assign rwd[1] = bus1.rd_wdata;
    assign rln[1] = bus1.rd_lane;

    retire_trace_buffer #(.LANES(2), .DEPTH(DEPTH), .XLEN(32), .POST_TRIG(POST0)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0),
        .arm(arm), .abort(abort), .trig_en(trig_en), .trig_pc(trig_pc), .force_trig(force_trig),
        .state(st[0]), .count(cnt[0]), .wrapped(wrp[0])
    );

    retire_trace_buffer #(.LANES(2), .DEPTH(DEPTH), .XLEN(32), .POST_TRIG(POST1)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1),
        .arm(arm), .abort(abort), .trig_en(trig_en), .trig_pc(trig_pc), .force_trig(force_trig),
        .state(st[1]), .count(cnt[1]), .wrapped(wrp[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    task automatic model_push(input int d, input int i);
        ent_t e;
        e.pc    = ret_pc[i*32 +: 32];
        e.rd    = ret_rd[i*5 +: 5];
        e.we    = ret_we[i];
        e.wdata = ret_wdata[i*32 +: 32];
        e.lane  = 1'(i);
        mq[d].push_back(e);
        if (mq[d].size() > DEPTH) begin
            void'(mq[d].pop_front());
            mw[d] = 1'b1;
        end
    endtask

    task automatic model_step(input int d);
        bit hit;
        int p;
        p = (d == 0) ? POST0 : POST1;
        if (abort) begin
            ms[d] = 0; mp[d] = 0; mw[d] = 1'b0; mq[d].delete();
            return;
        end
        case (ms[d])
            0: if (arm) begin
                ms[d] = 1; mw[d] = 1'b0; mq[d].delete();
            end
            1: begin
                hit = force_trig;
                for (int i = 0; i < 2; i++) begin
                    if (ret_valid[i]) begin
                        if (trig_en && ret_pc[i*32 +: 32] == trig_pc) hit = 1'b1;
                        model_push(d, i);
                    end
                end
                if (hit) begin
                    mp[d] = p;
                    ms[d] = (p == 0) ? 3 : 2;
                end
            end
            2: begin
                for (int i = 0; i < 2; i++) begin
                    if (ret_valid[i] && mp[d] > 0) begin
                        model_push(d, i);
                        mp[d]--;
                    end
                end
                if (mp[d] == 0) ms[d] = 3;
            end
            default: begin
                if (mq[d].size() == 0) ms[d] = 0;
                else if (rd_ready) begin
                    void'(mq[d].pop_front());
                    if (mq[d].size() == 0) ms[d] = 0;
                end
            end
        endcase
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                ms[d] = 0; mp[d] = 0; mw[d] = 1'b0; mq[d].delete();
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            bit   ev;
            ent_t e;
            ev = (ms[d] == 3) && (mq[d].size() > 0);
            e  = ev ? mq[d][0] : '0;
            chk($sformatf("d%0d_state", d),    64'(st[d]),  64'(ms[d]));
            chk($sformatf("d%0d_count", d),    64'(cnt[d]), 64'(mq[d].size()));
            chk($sformatf("d%0d_wrapped", d),  64'(wrp[d]), 64'(mw[d]));
            chk($sformatf("d%0d_rd_valid", d), 64'(rv[d]),  64'(ev));
            chk($sformatf("d%0d_rd_pc", d),    64'(rpc[d]), 64'(e.pc));
            chk($sformatf("d%0d_rd_rd", d),    64'(rrd[d]), 64'(e.rd));
            chk($sformatf("d%0d_rd_we", d),    64'(rwe[d]), 64'(e.we));
            chk($sformatf("d%0d_rd_wdata", d), 64'(rwd[d]), 64'(e.wdata));
            chk($sformatf("d%0d_rd_lane", d),  64'(rln[d]), 64'(e.lane));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        arm = 0; abort = 0; force_trig = 0; trig_en = 0; trig_pc = '0; rd_ready = 0;
        ret_valid = '0; ret_pc = '0; ret_rd = '0; ret_we = '0; ret_wdata = '0;
    endtask

    task automatic lane(input int i, input logic [31:0] pc, input logic [4:0] rd,
                        input logic we, input logic [31:0] wd);
        ret_valid[i]          = 1'b1;
        ret_pc[i*32 +: 32]    = pc;
        ret_rd[i*5 +: 5]      = rd;
        ret_we[i]             = we;
        ret_wdata[i*32 +: 32] = wd;
    endtask

    task automatic lane_pc(input int i, input logic [31:0] pc);
        lane(i, pc, pc[6:2], pc[2], pc ^ 32'hA5A5_0000);
    endtask

    task automatic do_abort();
        clear_in(); abort = 1; tick(); abort = 0;
    endtask

    task automatic do_arm();
        arm = 1; tick(); arm = 0;
    endtask

    task automatic drain(input int d, input logic [31:0] first, input int n);
        logic [31:0] e;
        for (int k = 0; k < n; k++) begin
            e = first + 32'(4 * k);
            chk("drain_valid", 64'(rv[d]), 64'd1);
            chk("drain_pc", 64'(rpc[d]), 64'(e));
            rd_ready = 1; tick();
        end
        rd_ready = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        chk("reset_state", 64'(st[0]), 64'd0);
        chk("reset_count", 64'(cnt[0]), 64'd0);
        chk("reset_rd_valid", 64'(rv[0]), 64'd0);
        chk("reset_rd_pc", 64'(rpc[0]), 64'd0);

        // 1: basic capture with PC-match trigger and POST_TRIG=2
        do_abort(); do_arm();
        chk("s1_armed", 64'(st[0]), 64'd1);
        trig_en = 1; trig_pc = 32'h0C;
        lane_pc(0, 32'h00); lane_pc(1, 32'h04); tick();
        lane_pc(0, 32'h08); lane_pc(1, 32'h0C); tick();
        chk("s1_d0_trig", 64'(st[0]), 64'd2);
        chk("s1_d1_frozen", 64'(st[1]), 64'd3);
        lane_pc(0, 32'h10); lane_pc(1, 32'h14); tick();
        chk("s1_frozen", 64'(st[0]), 64'd3);
        lane_pc(0, 32'h18); lane_pc(1, 32'h1C); tick();
        ret_valid = '0; trig_en = 0;
        chk("s1_count", 64'(cnt[0]), 64'd6);
        drain(0, 32'h00, 6);
        chk("s1_idle", 64'(st[0]), 64'd0);

        // 2: wrap with POST_TRIG=0
        do_abort(); do_arm();
        for (int k = 0; k < 12; k++) begin
            ret_valid = '0; lane_pc(0, 32'(4 * k)); tick();
        end
        ret_valid = '0; force_trig = 1; tick(); force_trig = 0;
        chk("s2_frozen", 64'(st[1]), 64'd3);
        chk("s2_count", 64'(cnt[1]), 64'd8);
        chk("s2_wrapped", 64'(wrp[1]), 64'd1);
        drain(1, 32'h10, 8);
        chk("s2_idle", 64'(st[1]), 64'd0);

        // 3: post counter at 1 with both lanes valid
        do_abort(); do_arm();
        force_trig = 1; tick(); force_trig = 0;
        lane_pc(1, 32'h38); tick(); ret_valid = '0;
        lane_pc(0, 32'h40); lane_pc(1, 32'h44); tick(); ret_valid = '0;
        chk("s3_frozen", 64'(st[0]), 64'd3);
        chk("s3_count", 64'(cnt[0]), 64'd2);
        chk("s3_first_lane", 64'(rln[0]), 64'd1);
        rd_ready = 1; tick(); rd_ready = 0;
        chk("s3_pc", 64'(rpc[0]), 64'h40);
        chk("s3_lane", 64'(rln[0]), 64'd0);
        rd_ready = 1; tick(); rd_ready = 0;
        chk("s3_idle", 64'(st[0]), 64'd0);

        // 4: compaction of a lone lane 1
        do_abort(); do_arm();
        ret_pc[31:0] = 32'h84;
        lane(1, 32'h80, 5'd5, 1'b1, 32'hDEAD);
        force_trig = 1; tick(); clear_in();
        chk("s4_count0", 64'(cnt[0]), 64'd1);
        chk("s4_count1", 64'(cnt[1]), 64'd1);
        chk("s4_pc", 64'(rpc[1]), 64'h80);
        chk("s4_rd", 64'(rrd[1]), 64'd5);
        chk("s4_we", 64'(rwe[1]), 64'd1);
        chk("s4_wdata", 64'(rwd[1]), 64'hDEAD);
        chk("s4_lane", 64'(rln[1]), 64'd1);

        // 5: backpressure on a frozen 3-entry buffer
        do_abort(); do_arm();
        lane_pc(0, 32'h00); lane_pc(1, 32'h04); tick(); ret_valid = '0;
        lane_pc(0, 32'h08); force_trig = 1; tick(); clear_in();
        chk("s5_count", 64'(cnt[1]), 64'd3);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s5_hold_pc", 64'(rpc[1]), 64'h00);
            chk("s5_hold_count", 64'(cnt[1]), 64'd3);
        end
        rd_ready = 1; repeat (3) tick(); rd_ready = 0;
        chk("s5_idle", 64'(st[1]), 64'd0);
        chk("s5_empty", 64'(cnt[1]), 64'd0);

        // 6: async reset mid-TRIGGERED, then abort+arm together
        do_abort(); do_arm();
        force_trig = 1; tick(); force_trig = 0;
        lane_pc(0, 32'h50); tick(); ret_valid = '0;
        chk("s6_trig", 64'(st[0]), 64'd2);
        #2 reset = 1'b0;
        #1;
        chk("s6_rst_state", 64'(st[0]), 64'd0);
        chk("s6_rst_count", 64'(cnt[0]), 64'd0);
        chk("s6_rst_wrapped", 64'(wrp[0]), 64'd0);
        chk("s6_rst_rd_valid", 64'(rv[0]), 64'd0);
        tick(); reset = 1'b1;
        do_arm();
        lane_pc(0, 32'h60); lane_pc(1, 32'h64); tick(); ret_valid = '0;
        abort = 1; arm = 1; tick(); clear_in();
        chk("s6_abort_state", 64'(st[0]), 64'd0);
        chk("s6_abort_count", 64'(cnt[0]), 64'd0);

        // randomized traffic, checked by the every-cycle compare against the model
        for (int c = 0; c < 3000; c++) begin
            abort      = ($urandom_range(0, 199) == 0);
            arm        = ($urandom_range(0, 7) == 0);
            trig_en    = ($urandom_range(0, 3) == 0);
            trig_pc    = 32'h100 + 32'(4 * $urandom_range(0, 15));
            force_trig = ($urandom_range(0, 39) == 0);
            rd_ready   = 1'($urandom_range(0, 1));
            for (int i = 0; i < 2; i++) begin
                ret_valid[i]          = 1'($urandom_range(0, 1));
                ret_pc[i*32 +: 32]    = 32'h100 + 32'(4 * $urandom_range(0, 15));
                ret_rd[i*5 +: 5]      = 5'($urandom);
                ret_we[i]             = 1'($urandom);
                ret_wdata[i*32 +: 32] = $urandom;
            end
            tick();
        end
        clear_in();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
